// File: rtl/lsu_addr_adder_pkg.sv
// Shared LSU address-generation types: request/answer structs, width and exception codes,
// plus the natural-alignment check reused by the memory request path.
package lsu_addr_adder_pkg;

  localparam int XLEN  = 64;
  localparam int TAG_W = 4;

  typedef enum logic [2:0] {
    LS_BYTE,
    LS_BYTE_U,
    LS_HALFWORD,
    LS_HALFWORD_U,
    LS_WORD,
    LS_WORD_U,
    LS_DOUBLEWORD
  } ldst_width_t;

  typedef enum logic [4:0] {
    E_LD_ADDR_MISALIGNED = 5'd4,
    E_ST_ADDR_MISALIGNED = 5'd6,
    E_UNKNOWN            = 5'd31
  } except_code_t;

  typedef enum logic {
    ADDR_DST_LB,
    ADDR_DST_SB
  } addr_dst_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    ldst_width_t      ls_type;
    logic [XLEN-1:0]  base;
    logic [XLEN-1:0]  offs;
  } adder_req_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  result;
    logic             except_raised;
    except_code_t     except_code;
  } adder_ans_t;

  function automatic logic is_misaligned(ldst_width_t width, logic [2:0] addr_lsb);
    case (width)
      LS_HALFWORD, LS_HALFWORD_U: return addr_lsb[0];
      LS_WORD, LS_WORD_U:         return |addr_lsb[1:0];
      LS_DOUBLEWORD:              return |addr_lsb;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_addr_adder_if.sv
// Request/answer handshake bundle between the load/store buffers and the address adder.
// Signal names are seen from the adder side.
interface lsu_addr_adder_if;
  import lsu_addr_adder_pkg::*;

  logic       lb_req_valid_i;
  logic       lb_req_ready_o;
  adder_req_t lb_req_i;
  logic       sb_req_valid_i;
  logic       sb_req_ready_o;
  adder_req_t sb_req_i;
  logic       lb_ans_valid_o;
  logic       lb_ans_ready_i;
  logic       sb_ans_valid_o;
  logic       sb_ans_ready_i;
  adder_ans_t ans_o;

  modport slave (
    input  lb_req_valid_i, lb_req_i, sb_req_valid_i, sb_req_i,
    input  lb_ans_ready_i, sb_ans_ready_i,
    output lb_req_ready_o, sb_req_ready_o, lb_ans_valid_o, sb_ans_valid_o, ans_o
  );

  modport master (
    output lb_req_valid_i, lb_req_i, sb_req_valid_i, sb_req_i,
    output lb_ans_ready_i, sb_ans_ready_i,
    input  lb_req_ready_o, sb_req_ready_o, lb_ans_valid_o, sb_ans_valid_o, ans_o
  );
endinterface

// File: rtl/lsu_addr_adder_rr_arbiter.sv
// Two-way LB/SB arbiter: round-robin (pointer advances only on an accepted request) or
// fixed SB priority. Grant is combinational; the pointer flop adds no latency.
module lsu_addr_adder_rr_arbiter #(
  parameter bit RR_ARB = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic lb_vld,
  input  logic sb_vld,
  input  logic accept,
  output logic gnt_lb,
  output logic gnt_sb
);

  logic lb_next;

  always_comb begin
    gnt_lb = 1'b0;
    gnt_sb = 1'b0;
    if (RR_ARB) begin
      if (lb_vld && sb_vld) begin
        gnt_lb = lb_next;
        gnt_sb = !lb_next;
      end else begin
        gnt_lb = lb_vld;
        gnt_sb = sb_vld;
      end
    end else begin
      gnt_sb = sb_vld;
      gnt_lb = lb_vld && !sb_vld;
    end
  end

  // After serving SB, LB is preferred next time both contend (and vice versa).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lb_next <= 1'b1;
    end else if (accept) begin
      lb_next <= gnt_sb;
    end
  end

endmodule

// File: rtl/lsu_addr_adder.sv
// Shared LB/SB address adder: arbitrate, base+offs, alignment check, one-cycle registered answer.
// Accepts a new request whenever the output register is empty or being drained the same edge.
module lsu_addr_adder
  import lsu_addr_adder_pkg::*;
#(
  parameter bit RR_ARB = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  lsu_addr_adder_if.slave      bus
);

  logic       out_vld;
  addr_dst_t  out_dst;
  adder_ans_t out_ans;

  logic       gnt_lb, gnt_sb;
  logic       dst_rdy, drain, can_accept, req_open;
  logic       lb_hs, sb_hs, accept;
  adder_req_t sel_req;
  addr_dst_t  sel_dst;
  logic [XLEN-1:0] sum;
  adder_ans_t nxt_ans;

  assign dst_rdy    = (out_dst == ADDR_DST_LB) ? bus.lb_ans_ready_i : bus.sb_ans_ready_i;
  assign drain      = out_vld && dst_rdy;
  assign can_accept = !out_vld || drain;
  // Requests are refused during reset and flush so no handshake can be half-taken.
  assign req_open   = can_accept && !flush_i && rst_ni;

  lsu_addr_adder_rr_arbiter #(.RR_ARB(RR_ARB)) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .lb_vld (bus.lb_req_valid_i),
    .sb_vld (bus.sb_req_valid_i),
    .accept (accept),
    .gnt_lb (gnt_lb),
    .gnt_sb (gnt_sb)
  );

  assign bus.lb_req_ready_o = gnt_lb && req_open;
  assign bus.sb_req_ready_o = gnt_sb && req_open;

  assign lb_hs  = bus.lb_req_valid_i && bus.lb_req_ready_o;
  assign sb_hs  = bus.sb_req_valid_i && bus.sb_req_ready_o;
  assign accept = lb_hs || sb_hs;

  assign sel_req = sb_hs ? bus.sb_req_i : bus.lb_req_i;
  assign sel_dst = sb_hs ? ADDR_DST_SB : ADDR_DST_LB;
  assign sum     = sel_req.base + sel_req.offs;

  always_comb begin
    nxt_ans               = '0;
    nxt_ans.tag           = sel_req.tag;
    nxt_ans.result        = sum;
    nxt_ans.except_raised = is_misaligned(sel_req.ls_type, sum[2:0]);
    nxt_ans.except_code   = E_UNKNOWN;
    if (nxt_ans.except_raised) begin
      nxt_ans.except_code = (sel_dst == ADDR_DST_SB) ? E_ST_ADDR_MISALIGNED
                                                      : E_LD_ADDR_MISALIGNED;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld <= 1'b0;
      out_dst <= ADDR_DST_LB;
      out_ans <= '0;
    end else if (flush_i) begin
      out_vld <= 1'b0;
    end else if (accept) begin
      out_vld <= 1'b1;
      out_dst <= sel_dst;
      out_ans <= nxt_ans;
    end else if (drain) begin
      out_vld <= 1'b0;
    end
  end

  assign bus.lb_ans_valid_o = out_vld && (out_dst == ADDR_DST_LB);
  assign bus.sb_ans_valid_o = out_vld && (out_dst == ADDR_DST_SB);
  assign bus.ans_o          = out_ans;

endmodule

// File: tb/tb_lsu_addr_adder.sv
// Directed bench for lsu_addr_adder: one round-robin instance (u0) and one fixed-priority instance (u1).
module tb_lsu_addr_adder;
  import lsu_addr_adder_pkg::*;

  logic clk;
  logic rst_ni;
  logic flush;
  int   vectors;
  int   miscompares;

  lsu_addr_adder_if b0 ();
  lsu_addr_adder_if b1 ();

  lsu_addr_adder #(.RR_ARB(1'b1)) u0 (.clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .bus(b0));
  lsu_addr_adder #(.RR_ARB(1'b0)) u1 (.clk_i(clk), .rst_ni(rst_ni), .flush_i(1'b0),  .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic adder_req_t mk(input logic [3:0] tag, input ldst_width_t w,
                                    input logic [63:0] base, input logic [63:0] offs);
    adder_req_t r;
    r.tag = tag; r.ls_type = w; r.base = base; r.offs = offs;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request on u0 for one cycle, check it is accepted, then sample after the edge.
  task automatic send(input bit to_sb, input adder_req_t r);
    @(negedge clk);
    b0.lb_req_valid_i = !to_sb;
    b0.sb_req_valid_i = to_sb;
    if (to_sb) b0.sb_req_i = r; else b0.lb_req_i = r;
    #1;
    chk(to_sb ? "sb_req_ready" : "lb_req_ready",
        to_sb ? b0.sb_req_ready_o : b0.lb_req_ready_o, 1);
    step();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_ni = 1'b0; flush = 1'b0;
    b0.lb_req_valid_i = 1'b1; b0.sb_req_valid_i = 1'b0;
    b0.lb_req_i = '0; b0.sb_req_i = '0;
    b0.lb_ans_ready_i = 1'b1; b0.sb_ans_ready_i = 1'b1;
    b1.lb_req_valid_i = 1'b0; b1.sb_req_valid_i = 1'b0;
    b1.lb_req_i = '0; b1.sb_req_i = '0;
    b1.lb_ans_ready_i = 1'b1; b1.sb_ans_ready_i = 1'b1;

    // Reset state
    step(); step();
    chk("rst_lb_req_ready", b0.lb_req_ready_o, 0);
    chk("rst_lb_ans_valid", b0.lb_ans_valid_o, 0);
    chk("rst_sb_ans_valid", b0.sb_ans_valid_o, 0);
    chk("rst_ans_o", b0.ans_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    b0.lb_req_valid_i = 1'b0;

    // Aligned doubleword load
    send(0, mk(4'd3, LS_DOUBLEWORD, 64'h1000, 64'h8));
    chk("dw_lb_valid", b0.lb_ans_valid_o, 1);
    chk("dw_sb_valid", b0.sb_ans_valid_o, 0);
    chk("dw_result", b0.ans_o.result, 64'h1008);
    chk("dw_tag", b0.ans_o.tag, 3);
    chk("dw_exc", b0.ans_o.except_raised, 0);
    chk("dw_code", b0.ans_o.except_code, E_UNKNOWN);

    // Misaligned word store, then load
    send(1, mk(4'd5, LS_WORD, 64'h2001, 64'h2));
    chk("wst_sb_valid", b0.sb_ans_valid_o, 1);
    chk("wst_lb_valid", b0.lb_ans_valid_o, 0);
    chk("wst_result", b0.ans_o.result, 64'h2003);
    chk("wst_exc", b0.ans_o.except_raised, 1);
    chk("wst_code", b0.ans_o.except_code, E_ST_ADDR_MISALIGNED);
    send(0, mk(4'd6, LS_WORD_U, 64'h2001, 64'h2));
    chk("wld_lb_valid", b0.lb_ans_valid_o, 1);
    chk("wld_code", b0.ans_o.except_code, E_LD_ADDR_MISALIGNED);

    // Other widths at boundaries
    send(0, mk(4'd1, LS_HALFWORD, 64'h11, 64'h0));
    chk("hw_exc", b0.ans_o.except_raised, 1);
    send(0, mk(4'd2, LS_DOUBLEWORD, 64'h1000, 64'h4));
    chk("dw4_exc", b0.ans_o.except_raised, 1);
    send(0, mk(4'd4, LS_WORD, 64'h1000, 64'h4));
    chk("w4_exc", b0.ans_o.except_raised, 0);
    send(0, mk(4'd9, LS_BYTE, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10));
    chk("wrap_result", b0.ans_o.result, 64'h8);
    chk("wrap_exc", b0.ans_o.except_raised, 0);

    // Both contend every cycle; last u0 grant was LB, so SB first. u1 serves SB only.
    b0.sb_req_i = mk(4'd1, LS_BYTE, 64'h100, 64'h0);
    b0.lb_req_i = mk(4'd2, LS_BYTE, 64'h200, 64'h0);
    b1.sb_req_i = mk(4'd1, LS_BYTE, 64'h100, 64'h0);
    b1.lb_req_i = mk(4'd2, LS_BYTE, 64'h200, 64'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b0.lb_req_valid_i = 1'b1; b0.sb_req_valid_i = 1'b1;
      b1.lb_req_valid_i = 1'b1; b1.sb_req_valid_i = 1'b1;
      #1;
      chk("rr_sb_ready", b0.sb_req_ready_o, (i % 2 == 0) ? 1 : 0);
      chk("rr_lb_ready", b0.lb_req_ready_o, (i % 2 == 0) ? 0 : 1);
      chk("fp_lb_ready", b1.lb_req_ready_o, 0);
      step();
      chk("rr_sb_valid", b0.sb_ans_valid_o, (i % 2 == 0) ? 1 : 0);
      chk("rr_tag", b0.ans_o.tag, (i % 2 == 0) ? 1 : 2);
      chk("fp_sb_valid", b1.sb_ans_valid_o, 1);
      chk("fp_lb_valid", b1.lb_ans_valid_o, 0);
    end
    @(negedge clk);
    b0.lb_req_valid_i = 1'b0; b0.sb_req_valid_i = 1'b0;
    b1.lb_req_valid_i = 1'b0; b1.sb_req_valid_i = 1'b0;
    step();
    chk("idle_lb_valid", b0.lb_ans_valid_o, 0);

    // Back-pressure: answer tag 7 held for 3 cycles, then drain + accept tag 8 on one edge
    @(negedge clk);
    b0.lb_ans_ready_i = 1'b0;
    send(0, mk(4'd7, LS_WORD, 64'h3000, 64'h4));
    chk("bp_valid", b0.lb_ans_valid_o, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b0.lb_req_valid_i = 1'b1; b0.sb_req_valid_i = 1'b1;
      b0.lb_req_i = mk(4'd8, LS_BYTE, 64'h4000, 64'h1);
      #1;
      chk("bp_lb_ready", b0.lb_req_ready_o, 0);
      chk("bp_sb_ready", b0.sb_req_ready_o, 0);
      step();
      chk("bp_hold_valid", b0.lb_ans_valid_o, 1);
      chk("bp_hold_tag", b0.ans_o.tag, 7);
      chk("bp_hold_result", b0.ans_o.result, 64'h3004);
    end
    @(negedge clk);
    b0.sb_req_valid_i = 1'b0;
    b0.lb_ans_ready_i = 1'b1;
    #1;
    chk("drain_lb_ready", b0.lb_req_ready_o, 1);
    step();
    chk("drain_valid", b0.lb_ans_valid_o, 1);
    chk("drain_tag", b0.ans_o.tag, 8);
    chk("drain_result", b0.ans_o.result, 64'h4001);

    // Flush with a pending answer and an SB request presented
    @(negedge clk);
    b0.lb_req_valid_i = 1'b0;
    b0.lb_ans_ready_i = 1'b0;
    step();
    chk("fl_pending", b0.lb_ans_valid_o, 1);
    @(negedge clk);
    flush = 1'b1;
    b0.sb_req_valid_i = 1'b1;
    b0.sb_req_i = mk(4'd10, LS_BYTE, 64'h5000, 64'h0);
    #1;
    chk("fl_sb_ready", b0.sb_req_ready_o, 0);
    step();
    chk("fl_lb_valid", b0.lb_ans_valid_o, 0);
    chk("fl_sb_valid", b0.sb_ans_valid_o, 0);
    @(negedge clk);
    flush = 1'b0;
    b0.sb_req_valid_i = 1'b0;

    // Reset pulse while an answer is pending
    send(0, mk(4'd11, LS_BYTE, 64'h6000, 64'h0));
    chk("rp_pending", b0.lb_ans_valid_o, 1);
    @(negedge clk);
    b0.lb_req_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rp_in_reset", b0.lb_ans_valid_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    b0.lb_ans_ready_i = 1'b1;
    step();
    chk("rp_lb_valid", b0.lb_ans_valid_o, 0);
    chk("rp_sb_valid", b0.sb_ans_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
